dial_encoder_tx: RTL and testbench

//  Rotary-dial emulator: the transmitting end of the 8-bit absolute encoder bus (re_in) read by the bank vault.

---
 rtl/dial_encoder_tx.sv | 157 +++++++++++++++
 tb/tb_dial_encoder_tx.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/dial_encoder_tx.sv
// dial_encoder_tx: rotary-dial emulator driving an 8-bit Gray-coded absolute
// encoder bus. The cw/ccw button holds become single steps, and a held button
// auto-repeats after a delay. The dial angle is kept in binary (position) and
// is also driven as a registered Gray code (re_out).
//
// Optional build macro: INPUT_SYNC_EN
//   When defined, cw/ccw pass through a 2-flop synchroniser (reset to 0),
//   which adds 2 cycles to all latencies.
//   When undefined, cw/ccw must already be synchronous to clock.
//
// state   | meaning
// IDLE    | no button held; a single request steps at once and enters HOLD
// HOLD    | button held, counting towards the first auto-repeat step
// REPEAT  | button held, stepping once every REPEAT_PERIOD cycles
module dial_encoder_tx #(
    parameter logic [7:0] STEP          = 8'd8,
    parameter logic [7:0] INIT_POS      = 8'd0,
    parameter int         REPEAT_DELAY  = 50,
    parameter int         REPEAT_PERIOD = 10
) (
    input  logic       clock,
    input  logic       n_reset,
    input  logic       cw,
    input  logic       ccw,
    output logic [7:0] re_out,
    output logic [7:0] position,
    output logic       step_pulse,
    output logic       dir
);

    localparam int MAX_CNT = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0] DELAY_TC  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_TC = CNT_W'(REPEAT_PERIOD - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] HOLD   = 2'd1;
    localparam logic [1:0] REPEAT = 2'd2;

    logic             cw_s;
    logic             ccw_s;
    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             do_step;
    logic             step_cw;
    logic             single_cw;
    logic             single_ccw;
    logic             held_ok;
    logic [7:0]       pos_nxt;

`ifdef INPUT_SYNC_EN
    logic [1:0] cw_sync;
    logic [1:0] ccw_sync;

    // Two-flop synchroniser for asynchronous board keys.
    always_ff @(posedge clock) begin
        if (!n_reset) begin
            cw_sync  <= 2'b00;
            ccw_sync <= 2'b00;
        end else begin
            cw_sync  <= {cw_sync[0], cw};
            ccw_sync <= {ccw_sync[0], ccw};
        end
    end

    assign cw_s  = cw_sync[1];
    assign ccw_s = ccw_sync[1];
`else
    assign cw_s  = cw;
    assign ccw_s = ccw;
`endif

    // Both buttons high counts as no request at all.
    assign single_cw  = cw_s & ~ccw_s;
    assign single_ccw = ccw_s & ~cw_s;
    // dir holds the button latched on entry to HOLD.
    assign held_ok    = dir ? single_cw : single_ccw;

    // Next-state, repeat counter and step decision.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        do_step   = 1'b0;
        step_cw   = dir;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (single_cw || single_ccw) begin
                    do_step   = 1'b1;
                    step_cw   = single_cw;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (!held_ok) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else if (cnt == DELAY_TC) begin
                    do_step   = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = REPEAT;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            REPEAT: begin
                if (!held_ok) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else if (cnt == PERIOD_TC) begin
                    do_step = 1'b1;
                    cnt_nxt = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    assign pos_nxt = step_cw ? (position + STEP) : (position - STEP);

    // FSM state and counter registers.
    always_ff @(posedge clock) begin
        if (!n_reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Angle, Gray bus, direction and pulse all update on the same step edge.
    always_ff @(posedge clock) begin
        if (!n_reset) begin
            position   <= INIT_POS;
            re_out     <= INIT_POS ^ (INIT_POS >> 1);
            step_pulse <= 1'b0;
            dir        <= 1'b0;
        end else begin
            step_pulse <= do_step;
            if (do_step) begin
                position <= pos_nxt;
                re_out   <= pos_nxt ^ (pos_nxt >> 1);
                dir      <= step_cw;
            end
        end
    end

endmodule

// File: tb/tb_dial_encoder_tx.sv
// Self-checking bench for dial_encoder_tx (STEP=8, REPEAT_DELAY=4,
// REPEAT_PERIOD=2, no input sync). Instance a uses INIT_POS=0, instance b
// uses INIT_POS=8'hF8 for the wrap-up case.
module tb_dial_encoder_tx;

    logic       clock = 1'b0;
    logic       n_reset = 1'b0;
    logic       cw_a = 1'b0, ccw_a = 1'b0;
    logic       cw_b = 1'b0, ccw_b = 1'b0;
    logic [7:0] re_a, pos_a, re_b, pos_b;
    logic       pulse_a, dir_a, pulse_b, dir_b;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      tag;
        bit         sel_b;
        logic [7:0] pos;
        logic [7:0] re;
        logic       pulse;
        logic       dir;
    } exp_t;

    exp_t sb[$];

    always #5 clock = ~clock;

    dial_encoder_tx #(.STEP(8'd8), .INIT_POS(8'h00), .REPEAT_DELAY(4), .REPEAT_PERIOD(2)) dut_a (
        .clock(clock), .n_reset(n_reset), .cw(cw_a), .ccw(ccw_a),
        .re_out(re_a), .position(pos_a), .step_pulse(pulse_a), .dir(dir_a)
    );

    dial_encoder_tx #(.STEP(8'd8), .INIT_POS(8'hF8), .REPEAT_DELAY(4), .REPEAT_PERIOD(2)) dut_b (
        .clock(clock), .n_reset(n_reset), .cw(cw_b), .ccw(ccw_b),
        .re_out(re_b), .position(pos_b), .step_pulse(pulse_b), .dir(dir_b)
    );

    function automatic logic [7:0] gray(input logic [7:0] v);
        return v ^ (v >> 1);
    endfunction

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    // One clock: drive inputs at negedge, queue the expectation, compare after posedge.
    task automatic cyc(input string tag, input logic rst_n, input logic a_cw, input logic a_ccw,
                       input logic b_cw, input bit sel_b, input logic [7:0] epos,
                       input logic epulse, input logic edir);
        exp_t e;
        @(negedge clock);
        n_reset = rst_n;
        cw_a    = a_cw;
        ccw_a   = a_ccw;
        cw_b    = b_cw;
        ccw_b   = 1'b0;
        e.tag = tag; e.sel_b = sel_b; e.pos = epos; e.re = gray(epos);
        e.pulse = epulse; e.dir = edir;
        sb.push_back(e);
        @(posedge clock);
        #1;
        e = sb.pop_front();
        if (e.sel_b) begin
            check8({e.tag, ".pos"}, pos_b, e.pos);
            check8({e.tag, ".re"}, re_b, e.re);
            check1({e.tag, ".pulse"}, pulse_b, e.pulse);
            check1({e.tag, ".dir"}, dir_b, e.dir);
        end else begin
            check8({e.tag, ".pos"}, pos_a, e.pos);
            check8({e.tag, ".re"}, re_a, e.re);
            check1({e.tag, ".pulse"}, pulse_a, e.pulse);
            check1({e.tag, ".dir"}, dir_a, e.dir);
        end
    endtask

    initial begin
        // Reset state.
        cyc("rst0", 0, 0, 0, 0, 0, 8'h00, 0, 0);
        cyc("rst1", 0, 0, 0, 0, 0, 8'h00, 0, 0);
        cyc("rst_b", 0, 0, 0, 0, 1, 8'hF8, 0, 0);
        cyc("idle", 1, 0, 0, 0, 0, 8'h00, 0, 0);

        // Single cw press.
        cyc("cw1", 1, 1, 0, 0, 0, 8'h08, 1, 1);
        cyc("cw1_rel", 1, 0, 0, 0, 0, 8'h08, 0, 1);
        cyc("cw1_rel2", 1, 0, 0, 0, 0, 8'h08, 0, 1);
        check8("cw1_re_lit", re_a, 8'h0C);

        // Single ccw press from 0 wraps down.
        cyc("rst2", 0, 0, 0, 0, 0, 8'h00, 0, 0);
        cyc("ccw1", 1, 0, 1, 0, 0, 8'hF8, 1, 0);
        cyc("ccw1_rel", 1, 0, 0, 0, 0, 8'hF8, 0, 0);
        check8("ccw1_re_lit", re_a, 8'h84);

        // Held cw: steps at c0, c4, c6, c8.
        cyc("rst3", 0, 0, 0, 0, 0, 8'h00, 0, 0);
        cyc("hold_c0", 1, 1, 0, 0, 0, 8'h08, 1, 1);
        cyc("hold_c1", 1, 1, 0, 0, 0, 8'h08, 0, 1);
        cyc("hold_c2", 1, 1, 0, 0, 0, 8'h08, 0, 1);
        cyc("hold_c3", 1, 1, 0, 0, 0, 8'h08, 0, 1);
        cyc("hold_c4", 1, 1, 0, 0, 0, 8'h10, 1, 1);
        cyc("hold_c5", 1, 1, 0, 0, 0, 8'h10, 0, 1);
        cyc("hold_c6", 1, 1, 0, 0, 0, 8'h18, 1, 1);
        cyc("hold_c7", 1, 1, 0, 0, 0, 8'h18, 0, 1);
        cyc("hold_c8", 1, 1, 0, 0, 0, 8'h20, 1, 1);
        cyc("hold_c9", 1, 1, 0, 0, 0, 8'h20, 0, 1);
        for (int i = 0; i < 3; i++) cyc("hold_rel", 1, 0, 0, 0, 0, 8'h20, 0, 1);
        check8("hold_re_lit", re_a, 8'h30);

        // Both buttons high: never a step.
        for (int i = 0; i < 6; i++) cyc("both", 1, 1, 1, 0, 0, 8'h20, 0, 1);
        cyc("both_rel", 1, 0, 0, 0, 0, 8'h20, 0, 1);

        // Release then immediate re-press is accepted the following cycle.
        cyc("rep_c0", 1, 0, 1, 0, 0, 8'h18, 1, 0);
        cyc("rep_rel", 1, 0, 0, 0, 0, 8'h18, 0, 0);
        cyc("rep_c2", 1, 0, 1, 0, 0, 8'h10, 1, 0);
        cyc("rep_rel2", 1, 0, 0, 0, 0, 8'h10, 0, 0);

        // Other button pressed while holding: back to IDLE, no step.
        cyc("oth_c0", 1, 1, 0, 0, 0, 8'h18, 1, 1);
        cyc("oth_c1", 1, 1, 1, 0, 0, 8'h18, 0, 1);
        cyc("oth_c2", 1, 1, 1, 0, 0, 8'h18, 0, 1);
        cyc("oth_rel", 1, 0, 0, 0, 0, 8'h18, 0, 1);

        // Reset while in REPEAT.
        cyc("rr_c0", 1, 1, 0, 0, 0, 8'h20, 1, 1);
        cyc("rr_c1", 1, 1, 0, 0, 0, 8'h20, 0, 1);
        cyc("rr_c2", 1, 1, 0, 0, 0, 8'h20, 0, 1);
        cyc("rr_c3", 1, 1, 0, 0, 0, 8'h20, 0, 1);
        cyc("rr_c4", 1, 1, 0, 0, 0, 8'h28, 1, 1);
        cyc("rr_c5", 1, 1, 0, 0, 0, 8'h28, 0, 1);
        cyc("rr_rst0", 0, 1, 0, 0, 0, 8'h00, 0, 0);
        cyc("rr_rst1", 0, 1, 0, 0, 0, 8'h00, 0, 0);
        cyc("rr_rst2", 0, 0, 0, 0, 0, 8'h00, 0, 0);
        for (int i = 0; i < 4; i++) cyc("rr_idle", 1, 0, 0, 0, 0, 8'h00, 0, 0);
        cyc("rr_repress", 1, 1, 0, 0, 0, 8'h08, 1, 1);
        cyc("rr_rel", 1, 0, 0, 0, 0, 8'h08, 0, 1);

        // Instance b: INIT_POS=F8, one cw step wraps up to 0.
        cyc("b_idle", 1, 0, 0, 0, 1, 8'hF8, 0, 0);
        cyc("b_cw", 1, 0, 0, 1, 1, 8'h00, 1, 1);
        cyc("b_rel", 1, 0, 0, 0, 1, 8'h00, 0, 1);
        check8("b_re_lit", re_b, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
